fir2d_phase_seq: RTL and testbench

//  Pixel sequencer for the 2D FIR datapath; sits directly upstream of the tap-control decoder.

---
 rtl/fir2d_pkg.sv | 17 +
 rtl/modn_cnt.sv | 39 +++
 rtl/fir2d_phase_seq.sv | 168 ++++++++++++++++
 tb/tb_fir2d_phase_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fir2d_pkg.sv
// Shared definitions for the 2D FIR phase sequencer and the tap-control
// decoder that consumes its phase code.
//   PHASE_W        width of the phase code bus
//   PHASE_LAST_DEF default final phase code of a sweep
//   state_e        sequencer FSM states
package fir2d_pkg;

  localparam int PHASE_W        = 4;
  localparam int PHASE_LAST_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/modn_cnt.sv
// Modulo-N counter with enable, synchronous clear and terminal flag.
//   clk, rst_n  clock, async active-low reset
//   clr         synchronous clear to 0 (priority over en)
//   en          advance by one, wrapping N-1 -> 0
//   cnt         current count
//   last        count is at N-1 (the next enabled step wraps)
module modn_cnt #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == W'(N - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = last ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fir2d_phase_seq.sv
// Pixel sequencer for the 2D FIR datapath. Accepts one pixel per handshake,
// sweeps the phase code 0..PHASE_LAST for it, tracks column/row, and issues
// FLUSH_PIX zero-data padding sweeps after the last pixel of a frame.
//   clk, rst_n           clock, async active-low reset
//   clr                  synchronous abort to IDLE with counters zeroed
//   in_valid/in_data     pixel offer; in_ready accepts
//   adv                  advance enable, 0 freezes everything
//   phase, phase_vld     phase code to the tap-control decoder
//   pix_data, pix_ld     latched pixel and its load pulse (aligned with phase 0)
//   pad                  current sweep is padding
//   col, row             position of the current sweep
//   frame_done           pulse on the final phase of the final flush sweep
//
// state | meaning
// IDLE  | waiting for a pixel, in_ready follows adv
// RUN   | sweeping a real pixel; back-to-back accept at the final phase
// FLUSH | sweeping zero padding after the last pixel of a frame
module fir2d_phase_seq
  import fir2d_pkg::*;
#(
  parameter int DW         = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int PHASE_LAST = PHASE_LAST_DEF,
  parameter int FLUSH_PIX  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  output logic                     in_ready,
  input  logic                     adv,
  output logic [PHASE_W-1:0]       phase,
  output logic                     phase_vld,
  output logic [DW-1:0]            pix_data,
  output logic                     pix_ld,
  output logic                     pad,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row,
  output logic                     frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int FL_N  = (FLUSH_PIX > 0) ? FLUSH_PIX : 1;
  localparam int FL_W  = (FL_N > 1) ? $clog2(FL_N) : 1;
  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(PHASE_LAST);

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [DW-1:0]        pix_data_q, pix_data_d;
  logic                 pix_ld_q, pix_ld_d;

  logic                 col_en, fl_en;
  logic                 col_last, row_last, fl_last;
  logic                 sweep_end, last_pix, accept;
  logic [FL_W-1:0]      fl_cnt_unused;

  // Only the terminal flag of the flush count drives any logic.
  modn_cnt #(.N(IMG_W), .W(COL_W)) u_col (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(col_en),
    .cnt(col), .last(col_last)
  );

  modn_cnt #(.N(IMG_H), .W(ROW_W)) u_row (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(col_en && col_last),
    .cnt(row), .last(row_last)
  );

  modn_cnt #(.N(FL_N), .W(FL_W)) u_flush (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(fl_en),
    .cnt(fl_cnt_unused), .last(fl_last)
  );

  assign sweep_end = adv && (phase_q == PH_LAST);
  assign last_pix  = col_last && row_last;

  // The last pixel of a frame never chains into another accept; the frame
  // either flushes or drops to IDLE first.
  assign in_ready = !clr && adv &&
                    ((state_q == IDLE) ||
                     (state_q == RUN && phase_q == PH_LAST && !last_pix));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pix_data_d = pix_data_q;
    pix_ld_d   = 1'b0;
    col_en     = 1'b0;
    fl_en      = 1'b0;
    frame_done = 1'b0;

    if (clr) begin
      state_d    = IDLE;
      phase_d    = '0;
      pix_data_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d    = RUN;
            phase_d    = '0;
            pix_data_d = in_data;
            pix_ld_d   = 1'b1;
          end
        end
        RUN: begin
          if (sweep_end) begin
            col_en  = 1'b1;
            phase_d = '0;
            if (last_pix) begin
              if (FLUSH_PIX == 0) begin
                state_d    = IDLE;
                frame_done = 1'b1;
              end else begin
                state_d    = FLUSH;
                pix_data_d = '0;
              end
            end else if (accept) begin
              pix_data_d = in_data;
              pix_ld_d   = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else if (adv) begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end
        FLUSH: begin
          if (sweep_end) begin
            fl_en   = 1'b1;
            phase_d = '0;
            if (fl_last) begin
              state_d    = IDLE;
              frame_done = 1'b1;
            end
          end else if (adv) begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      pix_data_q <= '0;
      pix_ld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pix_data_q <= pix_data_d;
      pix_ld_q   <= pix_ld_d;
    end
  end

  assign phase     = phase_q;
  assign phase_vld = (state_q != IDLE);
  assign pad       = (state_q == FLUSH);
  assign pix_data  = pix_data_q;
  assign pix_ld    = pix_ld_q;

endmodule

// File: tb/tb_fir2d_phase_seq.sv
module tb_fir2d_phase_seq;

  localparam int DW = 8, IMG_W = 4, IMG_H = 2, PL = 15, FP = 2;

  logic          clk = 1'b0;
  logic          rst_n, clr, in_valid, adv;
  logic [DW-1:0] in_data;
  logic          in_ready, phase_vld, pix_ld, pad, frame_done;
  logic [3:0]    phase;
  logic [DW-1:0] pix_data;
  logic [1:0]    col;
  logic [0:0]    row;

  int errors = 0, checks = 0, fd_cnt = 0, fd0 = 0, ncyc = 0;
  int exp_ph;

  fir2d_phase_seq #(
    .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .PHASE_LAST(PL), .FLUSH_PIX(FP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .adv(adv), .phase(phase), .phase_vld(phase_vld),
    .pix_data(pix_data), .pix_ld(pix_ld), .pad(pad),
    .col(col), .row(row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic run_one(input logic [DW-1:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
    repeat (16) tick();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; adv = 1'b0;
    #12;
    check("rst_phase",  phase, 0);
    check("rst_vld",    phase_vld, 0);
    check("rst_pix",    pix_data, 0);
    check("rst_ld",     pix_ld, 0);
    check("rst_pad",    pad, 0);
    check("rst_col",    col, 0);
    check("rst_row",    row, 0);
    check("rst_fd",     frame_done, 0);
    check("rst_ready",  in_ready, 0);
    tick();
    rst_n = 1'b1; adv = 1'b1;
    #1 check("idle_ready", in_ready, 1);

    // single pixel sweep; in_data changes after the accept must not matter
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    for (int k = 0; k < 16; k++) begin
      check("t1_phase", phase, k);
      check("t1_vld",   phase_vld, 1);
      check("t1_ld",    pix_ld, (k == 0));
      check("t1_pix",   pix_data, 8'hA5);
      check("t1_ready", in_ready, (k == 15));
      tick();
    end
    check("t1_idle",     phase_vld, 0);
    check("t1_col_step", col, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_col", col, 0);

    // full 4x2 frame with in_valid held high, data scrambled mid-sweep
    fd0 = fd_cnt;
    in_valid = 1'b1; in_data = 8'h10;
    tick();
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 16; k++) begin
        check("t2_phase", phase, k);
        check("t2_pix",   pix_data, 8'h10 + p);
        check("t2_ld",    pix_ld, (k == 0));
        check("t2_ready", in_ready, (k == 15) && (p != 7));
        if (k == 0) begin
          check("t2_col", col, p % 4);
          check("t2_row", row, p / 4);
          check("t2_pad", pad, 0);
        end
        if (k == 3)  in_data = 8'hEE;
        if (k == 14) in_data = 8'h10 + p + 1;
        tick();
      end
    end
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 16; k++) begin
        check("t2f_pad",   pad, 1);
        check("t2f_phase", phase, k);
        check("t2f_pix",   pix_data, 0);
        check("t2f_ready", in_ready, 0);
        check("t2f_fd",    frame_done, (s == 1) && (k == 15));
        check("t2f_pos",   {col, row}, 0);
        if (s == 1 && k == 0) in_valid = 1'b0;
        tick();
      end
    end
    check("t2_end_vld", phase_vld, 0);
    check("t2_end_pad", pad, 0);
    check("t2_end_pos", {col, row}, 0);
    check("t2_fd_once", fd_cnt - fd0, 1);

    // adv stall for 3 cycles at phase 7
    in_valid = 1'b1; in_data = 8'h33;
    tick();
    in_valid = 1'b0;
    ncyc = 0;
    while (phase_vld && ncyc < 40) begin
      adv = !(ncyc >= 7 && ncyc <= 9);
      #1;
      exp_ph = (ncyc <= 7) ? ncyc : ((ncyc <= 10) ? 7 : ncyc - 3);
      check("t3_phase", phase, exp_ph);
      if (!adv) begin
        check("t3_ready_stall", in_ready, 0);
        check("t3_ld_stall",    pix_ld, 0);
      end
      tick();
      ncyc++;
    end
    adv = 1'b1;
    check("t3_len", ncyc, 19);

    // clr mid-sweep at column 2
    run_one(8'h21);
    in_valid = 1'b1; in_data = 8'h44;
    tick();
    in_valid = 1'b0;
    check("t4_col2", col, 2);
    repeat (5) tick();
    check("t4_ph5", phase, 5);
    fd0 = fd_cnt;
    clr = 1'b1; in_valid = 1'b1;
    #1 check("t4_ready_clr", in_ready, 0);
    tick();
    check("t4_vld",   phase_vld, 0);
    check("t4_phase", phase, 0);
    check("t4_pos",   {col, row}, 0);
    check("t4_ld",    pix_ld, 0);
    #1 check("t4_ready_clr_idle", in_ready, 0);
    tick();
    clr = 1'b0;
    check("t4_no_acc", phase_vld, 0);
    in_data = 8'h55;
    #1 check("t4_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t4_new_ld",  pix_ld, 1);
    check("t4_new_col", col, 0);
    check("t4_new_pix", pix_data, 8'h55);
    check("t4_new_ph",  phase, 0);
    repeat (16) tick();
    check("t4_no_fd", fd_cnt - fd0, 0);

    // async reset in the middle of a flush sweep
    clr = 1'b1; tick(); clr = 1'b0;
    in_valid = 1'b1; in_data = 8'h01;
    tick();
    repeat (128) tick();
    repeat (5) tick();
    check("t5_in_flush", pad, 1);
    check("t5_ph5",      phase, 5);
    fd0 = fd_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("t5_pad",   pad, 0);
    check("t5_phase", phase, 0);
    check("t5_vld",   phase_vld, 0);
    check("t5_pos",   {col, row}, 0);
    check("t5_fd",    frame_done, 0);
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("t5_no_fd",   fd_cnt - fd0, 0);
    check("t5_end_vld", phase_vld, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
